dpram_be: RTL and testbench



---
 rtl/dpram_be.sv | 174 +++++++++++++++++
 tb/tb_dpram_be.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_be.sv
// Single-clock true dual-port RAM with per-lane write enables, selectable read-during-write
// behaviour, optional output register and a clear sequencer that fills memory after reset.
module dpram_be #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned RDW_MODE = 0,
    parameter int unsigned OUT_REG = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 clear,
    output logic                                 busy,
    input  logic [ADDR_WIDTH-1:0]                address_a,
    input  logic [DATA_WIDTH-1:0]                data_a,
    input  logic                                 enable_a,
    input  logic                                 wren_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteena_a,
    output logic [DATA_WIDTH-1:0]                q_a,
    output logic                                 q_valid_a,
    input  logic [ADDR_WIDTH-1:0]                address_b,
    input  logic [DATA_WIDTH-1:0]                data_b,
    input  logic                                 enable_b,
    input  logic                                 wren_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     byteena_b,
    output logic [DATA_WIDTH-1:0]                q_b,
    output logic                                 q_valid_b
);
    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $error("dpram_be: RDW_MODE must be 0, 1 or 2");
    end

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] base,
                                                    input logic [DATA_WIDTH-1:0] wdata,
                                                    input logic [NB-1:0]         be);
        logic [DATA_WIDTH-1:0] m;
        m = base;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                m[i*BYTE_WIDTH +: BYTE_WIDTH] = wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return m;
    endfunction

    // Clear sequencer
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    assign busy = (state_q == StClear);

    // User port qualification; ports are fully masked while clearing
    logic wr_a, wr_b, rd_a, rd_b, same_addr;
    logic [DATA_WIDTH-1:0] old_a, old_b, final_a, final_b, rdata_a, rdata_b;

    assign wr_a      = reset_n & enable_a & wren_a & ~busy;
    assign wr_b      = reset_n & enable_b & wren_b & ~busy;
    assign rd_a      = enable_a & ~busy & (~wren_a | (RDW_MODE != 2));
    assign rd_b      = enable_b & ~busy & (~wren_b | (RDW_MODE != 2));
    assign same_addr = (address_a == address_b);
    assign old_a     = mem[address_a];
    assign old_b     = mem[address_b];

    // Final word at each written address; A is applied over B so A wins per lane
    always_comb begin
        final_b = merge(old_b, data_b, byteena_b);
        final_a = merge((wr_b && same_addr) ? final_b : old_a, data_a, byteena_a);
        if (wr_a && same_addr) begin
            final_b = final_a;
        end
    end

    assign rdata_a = (RDW_MODE == 1 && wr_a) ? final_a : old_a;
    assign rdata_b = (RDW_MODE == 1 && wr_b) ? final_b : old_b;

    always_ff @(posedge clock) begin
        if (busy && reset_n) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else begin
            if (wr_b) mem[address_b] <= final_b;
            if (wr_a) mem[address_a] <= final_a;
        end
    end

    // First read stage: data register only loads on an issued read, so q holds otherwise
    logic                  s1_valid_a_q, s1_valid_b_q;
    logic [DATA_WIDTH-1:0] s1_data_a_q, s1_data_b_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_a_q <= 1'b0;
            s1_valid_b_q <= 1'b0;
            s1_data_a_q  <= '0;
            s1_data_b_q  <= '0;
        end else begin
            s1_valid_a_q <= rd_a;
            s1_valid_b_q <= rd_b;
            if (rd_a) s1_data_a_q <= rdata_a;
            if (rd_b) s1_data_b_q <= rdata_b;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_a_q, s2_valid_b_q;
        logic [DATA_WIDTH-1:0] s2_data_a_q, s2_data_b_q;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid_a_q <= 1'b0;
                s2_valid_b_q <= 1'b0;
                s2_data_a_q  <= '0;
                s2_data_b_q  <= '0;
            end else begin
                s2_valid_a_q <= s1_valid_a_q;
                s2_valid_b_q <= s1_valid_b_q;
                if (s1_valid_a_q) s2_data_a_q <= s1_data_a_q;
                if (s1_valid_b_q) s2_data_b_q <= s1_data_b_q;
            end
        end

        assign q_a       = s2_data_a_q;
        assign q_b       = s2_data_b_q;
        assign q_valid_a = s2_valid_a_q;
        assign q_valid_b = s2_valid_b_q;
    end else begin : g_no_out_reg
        assign q_a       = s1_data_a_q;
        assign q_b       = s1_data_b_q;
        assign q_valid_a = s1_valid_a_q;
        assign q_valid_b = s1_valid_b_q;
    end

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: three configurations share stimulus; a word-level model predicts
// memory, busy and per-port read results, checked every cycle on the falling edge.
module tb_dpram_be;
    localparam int NI = 3;
    localparam logic [15:0] CV = 16'hA5A5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        enable_a = 1'b0, enable_b = 1'b0, wren_a = 1'b0, wren_b = 1'b0;
    logic [1:0]  byteena_a = '0, byteena_b = '0;

    logic        busy_o [NI];
    logic [15:0] q_a_o [NI];
    logic [15:0] q_b_o [NI];
    logic        qv_a_o [NI];
    logic        qv_b_o [NI];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u0 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_o[0]),
        .address_a(address_a), .data_a(data_a), .enable_a(enable_a), .wren_a(wren_a),
        .byteena_a(byteena_a), .q_a(q_a_o[0]), .q_valid_a(qv_a_o[0]),
        .address_b(address_b), .data_b(data_b), .enable_b(enable_b), .wren_b(wren_b),
        .byteena_b(byteena_b), .q_b(q_b_o[0]), .q_valid_b(qv_b_o[0]));

    dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u1 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_o[1]),
        .address_a(address_a), .data_a(data_a), .enable_a(enable_a), .wren_a(wren_a),
        .byteena_a(byteena_a), .q_a(q_a_o[1]), .q_valid_a(qv_a_o[1]),
        .address_b(address_b), .data_b(data_b), .enable_b(enable_b), .wren_b(wren_b),
        .byteena_b(byteena_b), .q_b(q_b_o[1]), .q_valid_b(qv_b_o[1]));

    dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(2), .OUT_REG(0),
               .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u2 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .busy(busy_o[2]),
        .address_a(address_a), .data_a(data_a), .enable_a(enable_a), .wren_a(wren_a),
        .byteena_a(byteena_a), .q_a(q_a_o[2]), .q_valid_a(qv_a_o[2]),
        .address_b(address_b), .data_b(data_b), .enable_b(enable_b), .wren_b(wren_b),
        .byteena_b(byteena_b), .q_b(q_b_o[2]), .q_valid_b(qv_b_o[2]));

    // Reference model
    logic [15:0] mem_m [16];
    int          clr_left, clr_ptr;
    bit          line_v [NI][2][2];
    logic [15:0] line_d [NI][2][2];
    logic [15:0] exp_q [NI][2];
    bit          exp_v [NI][2];
    bit          exp_busy;

    function automatic int rdw_of(int i);
        return (i == 0) ? 0 : (i == 1) ? 1 : 2;
    endfunction

    function automatic int lat_of(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic logic [15:0] apply(logic [15:0] w, logic [15:0] d, logic [1:0] be);
        return {be[1] ? d[15:8] : w[15:8], be[0] ? d[7:0] : w[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        clr_left = 16;
        clr_ptr  = 0;
        exp_busy = 1'b1;
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                exp_q[i][p] = '0;
                exp_v[i][p] = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    line_v[i][p][s] = 1'b0;
                    line_d[i][p][s] = '0;
                end
            end
        end
    endtask

    task automatic model_edge();
        bit          iss [NI][2];
        logic [15:0] val [NI][2];
        logic [15:0] bef [2];
        logic [15:0] aft [2];
        bit          en, we;
        int          slot;
        if (!reset_n) return;
        for (int i = 0; i < NI; i++) begin
            iss[i][0] = 1'b0; iss[i][1] = 1'b0; val[i][0] = '0; val[i][1] = '0;
        end
        if (clr_left > 0) begin
            mem_m[clr_ptr] = CV;
            clr_ptr++;
            clr_left--;
        end else begin
            bef[0] = mem_m[address_a];
            bef[1] = mem_m[address_b];
            if (enable_b && wren_b) mem_m[address_b] = apply(mem_m[address_b], data_b, byteena_b);
            if (enable_a && wren_a) mem_m[address_a] = apply(mem_m[address_a], data_a, byteena_a);
            aft[0] = mem_m[address_a];
            aft[1] = mem_m[address_b];
            for (int p = 0; p < 2; p++) begin
                en = (p == 0) ? enable_a : enable_b;
                we = (p == 0) ? wren_a : wren_b;
                for (int i = 0; i < NI; i++) begin
                    if (en && !we) begin
                        iss[i][p] = 1'b1; val[i][p] = bef[p];
                    end else if (en && we && rdw_of(i) != 2) begin
                        iss[i][p] = 1'b1; val[i][p] = (rdw_of(i) == 1) ? aft[p] : bef[p];
                    end
                end
            end
            if (clear) begin
                clr_left = 16;
                clr_ptr  = 0;
            end
        end
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < 2; p++) begin
                line_v[i][p][0] = line_v[i][p][1];
                line_d[i][p][0] = line_d[i][p][1];
                line_v[i][p][1] = 1'b0;
                slot = lat_of(i) - 1;
                line_v[i][p][slot] = iss[i][p];
                line_d[i][p][slot] = val[i][p];
                exp_v[i][p] = line_v[i][p][0];
                if (line_v[i][p][0]) exp_q[i][p] = line_d[i][p][0];
            end
        end
        exp_busy = (clr_left > 0);
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d busy", i), busy_o[i], exp_busy);
            check($sformatf("u%0d q_a", i), q_a_o[i], exp_q[i][0]);
            check($sformatf("u%0d q_valid_a", i), qv_a_o[i], exp_v[i][0]);
            check($sformatf("u%0d q_b", i), q_b_o[i], exp_q[i][1]);
            check($sformatf("u%0d q_valid_b", i), qv_b_o[i], exp_v[i][1]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        model_edge();
    endtask

    task automatic set_a(bit en, bit we, int addr, logic [15:0] d, logic [1:0] be);
        enable_a = en; wren_a = we; address_a = 4'(addr); data_a = d; byteena_a = be;
    endtask

    task automatic set_b(bit en, bit we, int addr, logic [15:0] d, logic [1:0] be);
        enable_b = en; wren_b = we; address_b = 4'(addr); data_b = d; byteena_b = be;
    endtask

    task automatic idle();
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        clear = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy_o[0] && n < 40) begin
            tick();
            n++;
        end
        check(name, n, 16);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        // Write attempted while clearing must be dropped
        set_a(1, 1, 9, 16'h1234, 2'b11);
        count_busy("busy_cycles_after_reset");
        idle();

        for (int a = 0; a < 16; a++) begin
            set_a(1, 0, a, '0, '0);
            tick();
            check("clear_fill_q", q_a_o[0], CV);
            check("clear_fill_valid", qv_a_o[0], 1);
        end
        idle();
        tick();

        set_a(1, 1, 3, 16'h1234, 2'b11); tick();
        set_a(1, 1, 3, 16'hFF00, 2'b10); tick();
        set_a(1, 0, 3, '0, '0); tick();
        check("byteena_merge", q_a_o[0], 16'hFF34);

        set_a(1, 1, 5, 16'h0001, 2'b11); tick();
        set_a(1, 0, 0, '0, '0); tick();
        set_a(1, 1, 5, 16'h0002, 2'b11); tick();
        check("rdw0_q", q_a_o[0], 16'h0001);
        check("rdw0_valid", qv_a_o[0], 1);
        check("rdw2_q_hold", q_a_o[2], CV);
        check("rdw2_valid", qv_a_o[2], 0);
        idle(); tick();
        check("rdw1_q", q_a_o[1], 16'h0002);
        check("rdw1_valid", qv_a_o[1], 1);

        set_a(1, 1, 7, 16'hAAAA, 2'b01);
        set_b(1, 1, 7, 16'hBBBB, 2'b11);
        tick();
        idle();
        set_a(1, 0, 7, '0, '0); tick();
        check("dual_write_priority", q_a_o[0], 16'hBBAA);
        set_a(1, 1, 8, 16'h5555, 2'b11);
        set_b(1, 0, 8, '0, '0);
        tick();
        check("cross_read_old", q_b_o[0], CV);
        idle();

        set_b(1, 1, 1, 16'h1111, 2'b11); tick();
        set_b(1, 1, 2, 16'h2222, 2'b11); tick();
        set_b(1, 1, 3, 16'h3333, 2'b11); tick();
        idle(); tick();
        set_b(1, 0, 1, '0, '0); tick();
        check("oreg_v0", qv_b_o[1], 0);
        set_b(1, 0, 2, '0, '0); tick();
        check("oreg_q1", q_b_o[1], 16'h1111);
        check("oreg_v1", qv_b_o[1], 1);
        set_b(1, 0, 3, '0, '0); tick();
        check("oreg_q2", q_b_o[1], 16'h2222);
        idle(); tick();
        check("oreg_q3", q_b_o[1], 16'h3333);
        check("oreg_v3", qv_b_o[1], 1);
        tick();
        check("oreg_v_end", qv_b_o[1], 0);

        for (int c = 0; c < 3000; c++) begin
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  16'($urandom), 2'($urandom));
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                  16'($urandom), 2'($urandom));
            if ($urandom_range(0, 3) == 0) address_b = address_a;
            clear = ($urandom_range(0, 299) == 0);
            tick();
        end
        idle();
        repeat (20) tick();

        // Clear interrupted by reset restarts from address 0
        clear = 1'b1; tick();
        clear = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_q_a", q_a_o[0], 0);
        check("reset_q_valid_a", qv_a_o[0], 0);
        repeat (2) tick();
        reset_n = 1'b1;
        count_busy("busy_cycles_after_abort");
        idle();
        for (int a = 0; a < 16; a++) begin
            set_b(1, 0, a, '0, '0);
            tick();
            check("reclear_fill_q", q_b_o[0], CV);
        end
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
